dcache_wt: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the memory-stage dBUS master (loads, stores, Sv39 page-table walk reads) and the downstream memory bus. It consumes `dbus_req_t` requests and returns `dbus_resp_t` responses with the same protocol upstream and downstream. Read hits complete without a downstream transaction. Writes and uncached accesses are always forwarded.

---
 rtl/dcache_wt_pkg.sv | 50 +++++
 rtl/dcache_array.sv | 54 +++++
 rtl/dcache_wt.sv | 167 ++++++++++++++++
 tb/tb_dcache_wt.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wt_pkg.sv
// common: shared dBUS request/response types, access sizes and data-cache definitions.
// Rev 1.0
`default_nettype none

package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_LOOKUP = 2'd1,
    DC_MEM    = 2'd2,
    DC_RESP   = 2'd3
  } dcache_state_t;

  localparam logic [63:0] DCACHE_UNCACHED_TOP = 64'h8000_0000;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_d,
                                             input logic [63:0] new_d,
                                             input logic [7:0]  mask);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage, one async read port, one byte-masked write port.
// Rev 1.0
`default_nettype none

module dcache_array
  import common::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 61 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inv_all_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [63:0]      rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [7:0]       wr_mask_i,
  input  logic [63:0]      wr_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [63:0]          data_q [NUM_LINES];

  // Only the valid bits need a reset; tag/data are qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= byte_merge(data_q[wr_idx_i], wr_data_i, wr_mask_i);
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache on the dBUS.
// Rev 1.0
`default_nettype none

module dcache_wt
  import common::*;
#(
  parameter int          NUM_LINES    = 16,
  parameter logic [63:0] UNCACHED_TOP = DCACHE_UNCACHED_TOP
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp,
  input  logic       flush
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 61 - IDX_W;

  dcache_state_t state_q, state_d;
  dbus_req_t     req_q, req_d;
  dbus_req_t     mreq_q, mreq_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          hit_q, hit_d;
  logic          flush_pend_q, flush_pend_d;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_cached;
  logic             w_is_write;
  logic             w_hit;
  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [63:0]      arr_data;
  logic             arr_we;
  logic             arr_inv;
  logic [7:0]       arr_mask;
  logic [63:0]      arr_wdata;
  logic             w_resp;
  logic             unused_ok;

  assign w_idx      = req_q.addr[3 +: IDX_W];
  assign w_tag      = req_q.addr[63:3+IDX_W];
  assign w_cached   = (req_q.addr >= UNCACHED_TOP);
  assign w_is_write = (req_q.strobe != 8'h00);
  assign w_hit      = arr_valid && (arr_tag == w_tag) && w_cached;

  dcache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .inv_all_i (arr_inv),
    .rd_idx_i  (w_idx),
    .rd_valid_o(arr_valid),
    .rd_tag_o  (arr_tag),
    .rd_data_o (arr_data),
    .we_i      (arr_we),
    .wr_idx_i  (w_idx),
    .wr_tag_i  (w_tag),
    .wr_mask_i (arr_mask),
    .wr_data_i (arr_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= DC_IDLE;
      req_q        <= '0;
      mreq_q       <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mreq_q       <= mreq_d;
      rdata_q      <= rdata_d;
      hit_q        <= hit_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mreq_d       = mreq_q;
    rdata_d      = rdata_q;
    hit_d        = hit_q;
    flush_pend_d = flush_pend_q;
    arr_inv      = 1'b0;
    arr_we       = 1'b0;
    arr_mask     = 8'h00;
    arr_wdata    = mresp.data;

    if (flush && (state_q != DC_IDLE)) flush_pend_d = 1'b1;

    unique case (state_q)
      DC_IDLE: begin
        // A flush wins over a new request; that request is taken next cycle.
        if (flush || flush_pend_q) begin
          arr_inv      = 1'b1;
          flush_pend_d = 1'b0;
        end else if (dreq.valid) begin
          req_d   = dreq;
          state_d = DC_LOOKUP;
        end
      end
      DC_LOOKUP: begin
        hit_d = w_hit;
        if (w_hit && !w_is_write) begin
          rdata_d = arr_data;
          state_d = DC_RESP;
        end else begin
          mreq_d.valid = 1'b1;
          if (!w_is_write && w_cached) begin
            mreq_d.addr   = {req_q.addr[63:3], 3'b000};
            mreq_d.size   = MSIZE8;
            mreq_d.strobe = 8'h00;
            mreq_d.data   = '0;
          end else begin
            mreq_d.addr   = req_q.addr;
            mreq_d.size   = req_q.size;
            mreq_d.strobe = req_q.strobe;
            mreq_d.data   = req_q.data;
          end
          state_d = DC_MEM;
        end
      end
      DC_MEM: begin
        if (mresp.data_ok) begin
          mreq_d  = '0;
          rdata_d = mresp.data;
          state_d = DC_RESP;
          if (!w_is_write && w_cached) begin
            arr_we    = 1'b1;
            arr_mask  = 8'hFF;
            arr_wdata = mresp.data;
          end else if (w_is_write && hit_q) begin
            arr_we    = 1'b1;
            arr_mask  = req_q.strobe;
            arr_wdata = req_q.data;
          end
        end
      end
      DC_RESP: begin
        state_d = DC_IDLE;
      end
      default: begin
        state_d = DC_IDLE;
      end
    endcase
  end

  assign w_resp = (state_q == DC_RESP);
  assign mreq   = mreq_q;
  assign dresp  = '{addr_ok: w_resp, data_ok: w_resp, data: rdata_q};

  assign unused_ok = ^{req_q.valid, mresp.addr_ok};

endmodule

`default_nettype wire

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: scoreboard bench for dcache_wt with a behavioural downstream memory.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_dcache_wt;
  import common::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  always #5 clk = ~clk;

  dcache_wt #(
    .NUM_LINES   (16),
    .UNCACHED_TOP(64'h8000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp),
    .mreq (mreq),
    .mresp(mresp),
    .flush(flush)
  );

  typedef struct {
    logic        chk;
    logic [63:0] data;
  } exp_resp_t;

  exp_resp_t   resp_q[$];
  dbus_req_t   mreq_exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mreq_hs = 0;
  int          mem_lat = 1;
  logic        mem_en = 1'b1;
  logic        late_dok = 1'b0;
  logic [63:0] mem_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_mreq(input logic [63:0] addr, input msize_t size,
                          input logic [7:0] strobe, input logic [63:0] data);
    dbus_req_t e;
    e.valid  = 1'b1;
    e.addr   = addr;
    e.size   = size;
    e.strobe = strobe;
    e.data   = data;
    mreq_exp_q.push_back(e);
  endtask

  // Downstream memory: answers each mreq after mem_lat cycles and checks it against expectations.
  initial begin : mem_model
    int        cnt;
    dbus_req_t e;
    cnt   = 0;
    mresp = '0;
    forever begin
      @(negedge clk);
      mresp.data_ok = late_dok;
      mresp.addr_ok = late_dok;
      if (mem_en && mreq.valid) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt           = 0;
          mresp.data_ok = 1'b1;
          mresp.addr_ok = 1'b1;
          mresp.data    = mem_data;
          mreq_hs++;
          if (mreq_exp_q.size() == 0) begin
            check_eq("mreq_unexpected", 64'd1, 64'd0);
          end else begin
            e = mreq_exp_q.pop_front();
            check_eq("mreq_addr", mreq.addr, e.addr);
            check_eq("mreq_size", 64'(mreq.size), 64'(e.size));
            check_eq("mreq_strobe", 64'(mreq.strobe), 64'(e.strobe));
            if (e.strobe != 8'h00) check_eq("mreq_data", mreq.data, e.data);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : dok_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dresp.data_ok) check_eq("dok_consecutive", 64'(prev), 64'd0);
      prev = dresp.data_ok;
    end
  end

  // Issues one upstream request and waits for its response; exp_lat 0 skips the latency check.
  task automatic do_req(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                        input logic [63:0] data, input logic chk, input logic [63:0] exp_data,
                        input int exp_mreqs, input int exp_lat);
    int        start_hs;
    int        cyc;
    bit        done;
    exp_resp_t r;
    @(negedge clk);
    start_hs = mreq_hs;
    cyc      = 0;
    done     = 1'b0;
    r.chk    = chk;
    r.data   = exp_data;
    resp_q.push_back(r);
    dreq = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: data};
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dresp.data_ok) begin
        done = 1'b1;
        dreq = '0;
        r    = resp_q.pop_front();
        check_eq("resp_addr_ok", 64'(dresp.addr_ok), 64'd1);
        if (r.chk) check_eq($sformatf("rdata@%h", addr), dresp.data, r.data);
        if (exp_lat > 0) check_eq($sformatf("latency@%h", addr), 64'(cyc), 64'(exp_lat));
        check_eq($sformatf("mreq_count@%h", addr), 64'(mreq_hs - start_hs), 64'(exp_mreqs));
      end
    end
    if (!done) begin
      check_eq($sformatf("timeout@%h", addr), 64'd0, 64'd1);
      dreq = '0;
      resp_q.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    reset = 1'b0;
    flush = 1'b0;
    dreq  = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_dresp_data_ok", 64'(dresp.data_ok), 64'd0);
    check_eq("rst_dresp_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check_eq("rst_dresp_data", dresp.data, 64'd0);
    check_eq("rst_mreq_valid", 64'(mreq.valid), 64'd0);
    check_eq("rst_mreq_addr", mreq.addr, 64'd0);
    reset = 1'b1;

    // Cached read miss, then hit.
    mem_data = 64'h1122_3344_5566_7788;
    exp_mreq(64'h8000_0010, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 1, 3);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 0, 2);

    // Byte store hitting the line, then re-read sees the merged value.
    exp_mreq(64'h8000_0013, MSIZE1, 8'b0000_1000, 64'h0000_0000_AB00_0000);
    do_req(64'h8000_0013, MSIZE1, 8'b0000_1000, 64'h0000_0000_AB00_0000, 1'b0, 64'h0, 1, 3);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1122_3344_AB66_7788, 0, 2);

    // Narrow cached read miss is widened to an aligned doubleword fill.
    mem_data = 64'hCAFE_0000_0000_0024;
    exp_mreq(64'h8000_0020, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0024, MSIZE4, 8'h00, 64'h0, 1'b1, 64'hCAFE_0000_0000_0024, 1, 3);
    do_req(64'h8000_0024, MSIZE4, 8'h00, 64'h0, 1'b1, 64'hCAFE_0000_0000_0024, 0, 2);

    // Uncached reads always go downstream with original size.
    mem_data = 64'h0000_0000_DEAD_0001;
    exp_mreq(64'h1000_0000, MSIZE4, 8'h00, 64'h0);
    do_req(64'h1000_0000, MSIZE4, 8'h00, 64'h0, 1'b1, 64'h0000_0000_DEAD_0001, 1, 3);
    mem_data = 64'h0000_0000_DEAD_0002;
    exp_mreq(64'h1000_0000, MSIZE4, 8'h00, 64'h0);
    do_req(64'h1000_0000, MSIZE4, 8'h00, 64'h0, 1'b1, 64'h0000_0000_DEAD_0002, 1, 3);

    // Conflict on index 2: 0x90 evicts 0x10, which then misses again.
    mem_data = 64'h9999_0000_0000_0090;
    exp_mreq(64'h8000_0090, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0090, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h9999_0000_0000_0090, 1, 3);
    mem_data = 64'h1010_1010_1010_1010;
    exp_mreq(64'h8000_0010, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1010_1010_1010_1010, 1, 3);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1010_1010_1010_1010, 0, 2);

    // Write miss is forwarded but not allocated.
    exp_mreq(64'h8000_0050, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF);
    do_req(64'h8000_0050, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 1, 3);
    mem_data = 64'h5050_5050_5050_5050;
    exp_mreq(64'h8000_0050, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0050, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h5050_5050_5050_5050, 1, 3);

    // Flush during MEM: fill completes, then the pending flush invalidates everything.
    mem_lat  = 4;
    mem_data = 64'h3030_3030_3030_3030;
    exp_mreq(64'h8000_0030, MSIZE8, 8'h00, 64'h0);
    fork
      do_req(64'h8000_0030, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h3030_3030_3030_3030, 1, 6);
      begin
        w = 0;
        while (!mreq.valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    mem_lat  = 1;
    mem_data = 64'h3131_3131_3131_3131;
    exp_mreq(64'h8000_0030, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0030, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h3131_3131_3131_3131, 1, 0);
    mem_data = 64'h1212_1212_1212_1212;
    exp_mreq(64'h8000_0010, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h1212_1212_1212_1212, 1, 3);

    // Flush and request in the same IDLE cycle: flush first, so the cached line misses.
    mem_data = 64'h3232_3232_3232_3232;
    exp_mreq(64'h8000_0030, MSIZE8, 8'h00, 64'h0);
    fork
      do_req(64'h8000_0030, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h3232_3232_3232_3232, 1, 0);
      begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join

    // Reset in the middle of MEM abandons the transaction.
    mem_en = 1'b0;
    @(negedge clk);
    dreq = '{valid: 1'b1, addr: 64'h8000_0040, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    w = 0;
    while (!mreq.valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("mid_mem_mreq_valid", 64'(mreq.valid), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_mem_mreq_valid", 64'(mreq.valid), 64'd0);
    check_eq("rst_mid_mem_dresp_data", dresp.data, 64'd0);
    dreq = '0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b1;
    late_dok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    late_dok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("late_dok_dresp_data_ok", 64'(dresp.data_ok), 64'd0);
      check_eq("late_dok_mreq_valid", 64'(mreq.valid), 64'd0);
    end
    mem_en = 1'b1;

    // Reset cleared the valid bits.
    mem_data = 64'h4444_4444_4444_4444;
    exp_mreq(64'h8000_0010, MSIZE8, 8'h00, 64'h0);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b1, 64'h4444_4444_4444_4444, 1, 3);

    @(negedge clk);
    check_eq("mreq_exp_leftover", 64'(mreq_exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
